// File: rtl/sel_mux_pipe.sv
// N-to-1 operand multiplexer with a registered valid/ready output stage.
// Optional saturating out-of-range select counter: define SEL_MUX_ERR_COUNT_EN.
module sel_mux_pipe #(
  parameter  int WIDTH   = 5,
  parameter  int N_IN    = 3,
  parameter  int COUNT_W = 8,
  localparam int SEL_W   = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COUNT_W-1:0]    err_count
);

  // One extra bit so N_IN itself is representable when it is a power of two.
  localparam logic [SEL_W:0] N_IN_EXT = (SEL_W + 1)'(N_IN);

  logic             accept;
  logic [SEL_W:0]   sel_ext;
  logic             sel_oob;
  logic [WIDTH-1:0] mux_data;

  // Handshake: a word moves when valid && ready on the same rising edge.
  // in_ready depends only on the output register and out_ready, never on
  // in_valid; a held word stays stable while out_valid && !out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign sel_ext = {1'b0, sel};
  assign sel_oob = (sel_ext >= N_IN_EXT);

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel_ext == (SEL_W + 1)'(k)) mux_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel_err <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= mux_data;
      out_sel_err <= sel_oob;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef SEL_MUX_ERR_COUNT_EN
  logic [COUNT_W-1:0] err_q;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (accept && sel_oob && (err_q != {COUNT_W{1'b1}})) begin
      err_q <= err_q + COUNT_W'(1);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: directed vectors, a behavioural model checked every
// cycle, and literal expectations at key points. Two instances (COUNT_W 8 and 2).
module tb_sel_mux_pipe;
  localparam int W   = 5;
  localparam int N   = 3;
  localparam int SW  = 2;
`ifdef SEL_MUX_ERR_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W-1:0]  in_bus = {5'h1F, 5'h0A, 5'h10};
  logic [SW-1:0]   sel = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;

  logic            in_ready_a, out_sel_err_a, out_valid_a;
  logic [W-1:0]    out_data_a;
  logic [7:0]      err_count_a;
  logic            in_ready_b, out_sel_err_b, out_valid_b;
  logic [W-1:0]    out_data_b;
  logic [1:0]      err_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  sel_mux_pipe #(.WIDTH(W), .N_IN(N), .COUNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_sel_err(out_sel_err_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .err_count(err_count_a)
  );

  sel_mux_pipe #(.WIDTH(W), .N_IN(N), .COUNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_sel_err(out_sel_err_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .err_count(err_count_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected output word and counters from the spec rules.
  logic            m_valid = 1'b0;
  logic [W-1:0]    m_data  = '0;
  logic            m_err   = 1'b0;
  int              m_cnt_a = 0;
  int              m_cnt_b = 0;

  function automatic logic [W-1:0] pick(input int s, input logic [N*W-1:0] bus);
    if (s < N) return bus[s*W +: W];
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1'b1;
      m_data  = pick(int'(sel), in_bus);
      m_err   = (int'(sel) >= N);
      if (m_err && CNT_EN == 1) begin
        m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
        m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    check("valid_a", out_valid_a, m_valid);
    check("valid_b", out_valid_b, m_valid);
    check("in_ready_a", in_ready_a, !m_valid || out_ready);
    check("in_ready_b", in_ready_b, !m_valid || out_ready);
    check("data_a", out_data_a, m_data);
    check("data_b", out_data_b, m_data);
    check("sel_err_a", out_sel_err_a, m_err);
    check("sel_err_b", out_sel_err_b, m_err);
    check("err_count_a", err_count_a, m_cnt_a);
    check("err_count_b", err_count_b, m_cnt_b);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic r);
    sel       = SW'(s);
    in_valid  = v;
    out_ready = r;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset, idle
    tick(); tick();
    #2 rst = 1'b0;
    tick(); tick();
    check("lit_reset_valid", out_valid_a, 0);
    check("lit_reset_data", out_data_a, 0);
    check("lit_reset_cnt", err_count_a, 0);
    check("lit_reset_ready", in_ready_a, 1);

    // Back-to-back stream sel 0,1,2 then out-of-range 3
    drive(0, 1, 1); tick();
    check("lit_s0_data", out_data_a, 5'h10);
    check("lit_s0_valid", out_valid_a, 1);
    drive(1, 1, 1); tick();
    check("lit_s1_data", out_data_a, 5'h0A);
    drive(2, 1, 1); tick();
    check("lit_s2_data", out_data_a, 5'h1F);
    check("lit_s2_err", out_sel_err_a, 0);
    drive(3, 1, 1); tick();
    check("lit_s3_data", out_data_a, 5'h00);
    check("lit_s3_err", out_sel_err_a, 1);
    check("lit_s3_cnt", err_count_a, CNT_EN);

    // Backpressure: hold 1F for four cycles while inputs toggle
    drive(2, 1, 1); tick();
    check("lit_bp_load", out_data_a, 5'h1F);
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? 3 : 0, 1, 0);
      in_bus = (i % 2 == 0) ? {5'h03, 5'h05, 5'h07} : {5'h1F, 5'h0A, 5'h10};
      #1;
      check("lit_bp_ready", in_ready_a, 0);
      tick();
      check("lit_bp_hold", out_data_a, 5'h1F);
      check("lit_bp_cnt", err_count_a, CNT_EN);
    end
    in_bus = {5'h1F, 5'h0A, 5'h10};
    drive(0, 1, 1); tick();
    check("lit_bp_release", out_data_a, 5'h10);
    check("lit_bp_release_valid", out_valid_a, 1);

    // Saturation on the COUNT_W=2 instance
    drive(0, 0, 1); tick();
    rst = 1'b1; #2 rst = 1'b0;
    drive(3, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lit_sat_cnt", err_count_b, (CNT_EN == 1) ? sat_exp[i] : 0);
    end

    // Async reset while holding a word with err_count=2
    drive(0, 0, 1); tick();
    rst = 1'b1; #2 rst = 1'b0;
    drive(3, 1, 1); tick(); tick();
    drive(0, 0, 0); tick();
    check("lit_pre_rst_valid", out_valid_a, 1);
    check("lit_pre_rst_cnt", err_count_a, 2 * CNT_EN);
    rst = 1'b1;
    #1;
    check("lit_rst_valid", out_valid_a, 0);
    check("lit_rst_cnt", err_count_a, 0);
    check("lit_rst_ready", in_ready_a, 1);
    drive(1, 1, 0);
    #1 rst = 1'b0;
    tick();
    check("lit_post_rst_data", out_data_a, 5'h0A);
    check("lit_post_rst_valid", out_valid_a, 1);

    // Mixed valid/ready pattern, checked by the model
    for (int i = 0; i < 20; i++) begin
      drive(i % 4, (i % 3) != 0, (i % 5) != 1);
      in_bus = (i % 2 == 0) ? {5'h1F, 5'h0A, 5'h10} : {5'h11, 5'h04, 5'h19};
      tick();
    end
    drive(0, 0, 1); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
